if_fetch: RTL
=============

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 Port clk  input  1  rising-edge clock for all state.
REQ-003 Port rst  input  1  asynchronous reset, active-high.
REQ-004 Port stall_i  input  1  downstream stall; 1 holds IF/ID outputs.
REQ-005 Port branch_en_i  input  1  redirect request (present only with IF_BRANCH_EN).
REQ-006 Port branch_addr_i  input  16  redirect target (present only with IF_BRANCH_EN).
REQ-007 Port rom_ce_o  output  1  instruction-memory request.
REQ-008 Port rom_addr_o  output  16  instruction address, equal to internal pc.
REQ-009 Port rom_data_i  input  16  instruction word, valid when rom_ready_i=1.
REQ-010 Port rom_ready_i  input  1  memory has data for rom_addr_o this cycle.
REQ-011 Port id_pc_o  output  16  PC of the instruction presented to decode.
REQ-012 Port id_inst_o  output  16  instruction presented to decode.
REQ-013 Port id_valid_o  output  1  id_pc_o/id_inst_o hold a real instruction.

Function
REQ-014 Internal state: 16-bit pc, 16-bit skid buffer (inst + pc), FSM with states IDLE, REQ, HOLD.
REQ-015 IDLE: rom_ce_o=0; next edge -> REQ unconditionally.
REQ-016 REQ: rom_ce_o=1, rom_addr_o=pc.
REQ-017 REQ, rom_ready_i=1, stall_i=0 at edge: id_pc_o<=pc, id_inst_o<=rom_data_i, id_valid_o<=1, pc<=pc+1, stay REQ.
REQ-018 REQ, rom_ready_i=1, stall_i=1 at edge: buffer<=(pc, rom_data_i), pc<=pc+1, id outputs unchanged, -> HOLD.
REQ-019 REQ, rom_ready_i=0, stall_i=0 at edge: bubble: id_inst_o<=16'h0000, id_valid_o<=0, id_pc_o unchanged, pc unchanged.
REQ-020 REQ, rom_ready_i=0, stall_i=1: all registers unchanged.
REQ-021 HOLD: rom_ce_o=0; stall_i=0 at edge -> id outputs<=buffer, id_valid_o<=1, -> REQ; stall_i=1 -> remain HOLD, no change.
REQ-022 Throughput with rom_ready_i tied 1 and no stall: one instruction per cycle; first valid output (pc 0) after the 2nd rising edge following reset release.
REQ-023 pc increment SHALL wrap 16'hFFFF -> 16'h0000 with no flag.
REQ-024 No instruction SHALL be dropped or duplicated across any stall sequence.

Reset
REQ-025 While rst=1: pc=0, state IDLE, buffer=0, rom_ce_o=0, rom_addr_o=0, id_pc_o=0, id_inst_o=0, id_valid_o=0.
REQ-026 Reset asserted mid-fetch or in HOLD SHALL discard buffered data immediately, independent of clk.

Configuration
REQ-027 Macro IF_BRANCH_EN defined: branch_en_i/branch_addr_i present; branch_en_i=1 at edge (any state except reset) SHALL set pc<=branch_addr_i, id_inst_o<=0, id_valid_o<=0, discard buffer, state -> REQ; branch has priority over stall_i and rom_ready_i.
REQ-028 Macro IF_BRANCH_EN undefined: ports absent, pc advances only by REQ-017/REQ-018.

Verification
REQ-029 Reset release, rom_ready_i=1, rom_data_i=16'h3443+pc, no stall -> id_pc_o 0,1,2,... on consecutive cycles, id_inst_o 16'h3443,16'h3444,..., first valid after 2nd edge.
REQ-030 Steady fetch, stall_i=1 for 3 cycles while pc=5 -> id_pc_o holds 4; HOLD buffers pc 5; after release id_pc_o=5 then 6, no gaps or repeats.
REQ-031 rom_ready_i=0 for 2 cycles at pc=8 -> id_valid_o=0 two cycles, id_inst_o=0, then id_pc_o=8 valid.
REQ-032 Preload pc near 16'hFFFF via branch (IF_BRANCH_EN) to 16'hFFFE -> id_pc_o 16'hFFFE,16'hFFFF,16'h0000.
REQ-033 IF_BRANCH_EN: branch_en_i=1, branch_addr_i=16'h0040 while in HOLD with stall_i=1 -> id_valid_o=0 next cycle, buffered inst discarded, next valid id_pc_o=16'h0040.
REQ-034 rst pulsed asynchronously mid-cycle during REQ -> all outputs 0 before next clk edge; restart per REQ-029.

Source files
------------

// File: rtl/if_fetch_if.sv
// ============================================================================
// Module   : if_fetch_if
// Brief    : Instruction-fetch bus bundle (ROM request side, decode side, control).
//            Branch-redirect signals exist only when IF_BRANCH_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface if_fetch_if;
    logic        stall_i;
`ifdef IF_BRANCH_EN
    logic        branch_en_i;
    logic [15:0] branch_addr_i;
`endif
    logic        rom_ce_o;
    logic [15:0] rom_addr_o;
    logic [15:0] rom_data_i;
    logic        rom_ready_i;
    logic [15:0] id_pc_o;
    logic [15:0] id_inst_o;
    logic        id_valid_o;

    // Fetch-unit view
    modport master (
        input  stall_i,
`ifdef IF_BRANCH_EN
        input  branch_en_i,
        input  branch_addr_i,
`endif
        output rom_ce_o,
        output rom_addr_o,
        input  rom_data_i,
        input  rom_ready_i,
        output id_pc_o,
        output id_inst_o,
        output id_valid_o
    );

    // Environment view (memory + decode + control)
    modport slave (
        output stall_i,
`ifdef IF_BRANCH_EN
        output branch_en_i,
        output branch_addr_i,
`endif
        input  rom_ce_o,
        input  rom_addr_o,
        output rom_data_i,
        output rom_ready_i,
        input  id_pc_o,
        input  id_inst_o,
        input  id_valid_o
    );
endinterface

`default_nettype wire

// File: rtl/if_fetch.sv
// ============================================================================
// Module   : if_fetch
// Brief    : Single-issue instruction fetch with one-entry skid buffer for
//            decode stalls. Optional redirect enabled by macro IF_BRANCH_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch (
    input  wire logic  clk,
    input  wire logic  rst,
    if_fetch_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      r_state,    w_state;
    logic [15:0] r_pc,       w_pc;
    logic [15:0] r_buf_pc,   w_buf_pc;
    logic [15:0] r_buf_inst, w_buf_inst;
    logic [15:0] r_id_pc,    w_id_pc;
    logic [15:0] r_id_inst,  w_id_inst;
    logic        r_id_valid, w_id_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pc       <= 16'h0000;
            r_buf_pc   <= 16'h0000;
            r_buf_inst <= 16'h0000;
            r_id_pc    <= 16'h0000;
            r_id_inst  <= 16'h0000;
            r_id_valid <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_pc       <= w_pc;
            r_buf_pc   <= w_buf_pc;
            r_buf_inst <= w_buf_inst;
            r_id_pc    <= w_id_pc;
            r_id_inst  <= w_id_inst;
            r_id_valid <= w_id_valid;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_pc       = r_pc;
        w_buf_pc   = r_buf_pc;
        w_buf_inst = r_buf_inst;
        w_id_pc    = r_id_pc;
        w_id_inst  = r_id_inst;
        w_id_valid = r_id_valid;

        case (r_state)
            S_IDLE: w_state = S_REQ;
            S_REQ: begin
                if (bus.rom_ready_i) begin
                    // pc advances on every accepted word; a stalled word parks in the skid buffer
                    w_pc = r_pc + 16'h0001;
                    if (bus.stall_i) begin
                        w_buf_pc   = r_pc;
                        w_buf_inst = bus.rom_data_i;
                        w_state    = S_HOLD;
                    end else begin
                        w_id_pc    = r_pc;
                        w_id_inst  = bus.rom_data_i;
                        w_id_valid = 1'b1;
                    end
                end else if (!bus.stall_i) begin
                    w_id_inst  = 16'h0000;
                    w_id_valid = 1'b0;
                end
            end
            S_HOLD: begin
                if (!bus.stall_i) begin
                    w_id_pc    = r_buf_pc;
                    w_id_inst  = r_buf_inst;
                    w_id_valid = 1'b1;
                    w_state    = S_REQ;
                end
            end
            default: w_state = S_IDLE;
        endcase

`ifdef IF_BRANCH_EN
        // Redirect overrides stall and memory readiness
        if (bus.branch_en_i) begin
            w_pc       = bus.branch_addr_i;
            w_id_inst  = 16'h0000;
            w_id_valid = 1'b0;
            w_buf_pc   = 16'h0000;
            w_buf_inst = 16'h0000;
            w_state    = S_REQ;
        end
`endif
    end

    assign bus.rom_ce_o   = (r_state == S_REQ);
    assign bus.rom_addr_o = r_pc;
    assign bus.id_pc_o    = r_id_pc;
    assign bus.id_inst_o  = r_id_inst;
    assign bus.id_valid_o = r_id_valid;

endmodule

`default_nettype wire
